// File: rtl/aud_record_ctrl.sv
// ---------------------------------------------------------------------------
// aud_record_ctrl
//   Capture side of the audio path. Deserialises left-channel I2S words from
//   the codec ADC and writes each one to SRAM at consecutive addresses. When a
//   session ends, the number of samples written is reported on o_rec_len so
//   that playback can use it as its stop address.
//
// Ports
//   i_clk, i_rst_n     system clock, asynchronous active-low reset
//   i_start            level: start from IDLE / resume from PAUSE
//   i_pause            level: pause recording
//   i_stop             level: stop recording (highest priority)
//   i_bclk, i_adclrck  codec bit clock and LR clock (slow, oversampled here)
//   i_adcdat           codec serial data, MSB first
//   o_sram_addr        write address (the write pointer)
//   o_sram_data        sample being written, held while o_sram_we is low
//   o_sram_we          one-cycle write strobe
//   o_rec_len          samples written in the most recently ended session
//   o_state            0 IDLE, 1 RECORD, 2 PAUSE
//   o_fin              one-cycle pulse when a session ends
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no session; waiting for i_start
// S_RECORD | captured left words are written to SRAM
// S_PAUSE  | capture continues but nothing is written; pointer held
// ---------------------------------------------------------------------------
module aud_record_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned MAX_ADDR = 2**ADDR_W-1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_bclk,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_data,
  output logic              o_sram_we,
  output logic [ADDR_W:0]   o_rec_len,
  output logic [1:0]        o_state,
  output logic              o_fin
);

  localparam int unsigned       CNT_W = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PAUSE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Oversampled codec pins; data is registered alongside BCLK so the bit
  // seen on a detected rising edge is the one present at that edge.
  logic bclk_q, bclk_prev_q, lrck_q, lrck_prev_q, dat_q;
  logic bclk_rise, lrck_fall;

  logic              armed_q, skip_q, done_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic [ADDR_W:0]   rec_len_q, rec_len_d;
  logic              fin_q, fin_d;

  logic              cap_clr, ptr_clr, wr_ok, end_at_max;
  logic [ADDR_W:0]   wr_count;

  assign bclk_rise = bclk_q & ~bclk_prev_q;
  assign lrck_fall = lrck_prev_q & ~lrck_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_q      <= 1'b0;
      bclk_prev_q <= 1'b0;
      lrck_q      <= 1'b0;
      lrck_prev_q <= 1'b0;
      dat_q       <= 1'b0;
    end else begin
      bclk_q      <= i_bclk;
      bclk_prev_q <= bclk_q;
      lrck_q      <= i_adclrck;
      lrck_prev_q <= lrck_q;
      dat_q       <= i_adcdat;
    end
  end

  // Deserialiser. A state change into RECORD or PAUSE disarms it so that a
  // partly received word is dropped and capture realigns on the next frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      armed_q <= 1'b0;
      skip_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (cap_clr) begin
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (lrck_fall) begin
      armed_q <= 1'b1;
      skip_q  <= 1'b1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (armed_q && bclk_rise) begin
        if (skip_q) begin
          // I2S one-bit delay after the LR clock change
          skip_q <= 1'b0;
        end else begin
          shift_q <= {shift_q[DATA_W-2:0], dat_q};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            armed_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      end
    end
  end

  // A write in flight this cycle still counts toward the session length.
  assign wr_count   = {1'b0, ptr_q} + {{ADDR_W{1'b0}}, we_q};
  assign end_at_max = we_q && (ptr_q == MAX_A);
  assign wr_ok      = (state_q == S_RECORD) && done_q && !i_stop && !i_pause;

  always_comb begin
    state_d   = state_q;
    cap_clr   = 1'b0;
    ptr_clr   = 1'b0;
    fin_d     = 1'b0;
    rec_len_d = rec_len_q;
    unique case (state_q)
      S_IDLE: begin
        if (!i_stop && !i_pause && i_start) begin
          state_d = S_RECORD;
          cap_clr = 1'b1;
          ptr_clr = 1'b1;
        end
      end
      S_RECORD: begin
        if (i_stop || end_at_max) begin
          state_d   = S_IDLE;
          fin_d     = 1'b1;
          rec_len_d = wr_count;
        end else if (i_pause) begin
          state_d = S_PAUSE;
          cap_clr = 1'b1;
        end
      end
      S_PAUSE: begin
        if (i_stop) begin
          state_d   = S_IDLE;
          fin_d     = 1'b1;
          rec_len_d = wr_count;
        end else if (!i_pause && i_start) begin
          state_d = S_RECORD;
          cap_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_d   = wr_ok;
    data_d = wr_ok ? shift_q : data_q;
    ptr_d  = ptr_q;
    if (ptr_clr) begin
      ptr_d = '0;
    end else if (we_q && (ptr_q != MAX_A)) begin
      // saturates at MAX_A; that write ends the session instead of wrapping
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      rec_len_q <= '0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      rec_len_q <= rec_len_d;
      fin_q     <= fin_d;
    end
  end

  assign o_sram_addr = ptr_q;
  assign o_sram_data = data_q;
  assign o_sram_we   = we_q;
  assign o_rec_len   = rec_len_q;
  assign o_state     = state_q;
  assign o_fin       = fin_q;

endmodule
